// File: rtl/ara_eoc_monitor_if.sv
// ---------------------------------------------------------------------------
// ara_eoc_monitor_if
//   Bundles the per-channel tohost-style exit words observed by
//   ara_eoc_monitor.
//
//   Handshake: exit_valid[c] qualifies exit_data[c*ExitWidth +: ExitWidth]
//   for the current clock edge. There is no ready. The monitor samples every
//   valid word on every edge and never applies backpressure. A producer may
//   keep valid high, or repost, for as long as it likes. Only the first word
//   with bit0 set that arrives while the monitor is running is kept.
//
//   Signals
//     exit_valid  NrChannels            per-channel word valid
//     exit_data   NrChannels*ExitWidth  per-channel words, ch0 in LSBs
//   Modports
//     master  drives the words (harness / bench)
//     slave   observes the words (monitor)
// ---------------------------------------------------------------------------
interface ara_eoc_monitor_if #(
   parameter int unsigned NrChannels = 4,
   parameter int unsigned ExitWidth  = 32
);
   logic [NrChannels-1:0]           exit_valid;
   logic [NrChannels*ExitWidth-1:0] exit_data;

   modport master (output exit_valid, output exit_data);
   modport slave  (input  exit_valid, input  exit_data);
endinterface

// File: rtl/ara_eoc_monitor.sv
// ---------------------------------------------------------------------------
// ara_eoc_monitor
//   Multi-channel end-of-computation monitor. It counts run cycles and
//   captures the first exit word per channel, together with a timestamp.
//   It produces one aggregate pass/fail/timeout verdict and can optionally
//   enforce a cycle budget.
//
//   Ports
//     clk_i, rst_i   clock, synchronous active-high reset
//     en_i           start a run (only looked at in IDLE)
//     exit_if        exit words (ara_eoc_monitor_if.slave)
//     exited_o       sticky per-channel capture flags
//     chan_cycles_o  cycle counter value at each channel's capture
//     cycles_o       run-cycle counter (saturating)
//     done_o         verdict valid (sticky until reset)
//     pass_o         no failing code and no timeout (only while done_o)
//     timeout_o      budget ran out before the finish condition
//     fail_chan_o    first failing channel (lowest index on a tie)
//     fail_code_o    exit code of fail_chan_o
//     state_o        FSM state for debug / checkers (0 IDLE, 1 RUN, 2 DONE)
// ---------------------------------------------------------------------------
module ara_eoc_monitor #(
   parameter int unsigned          NrChannels = 4,
   parameter int unsigned          ExitWidth  = 32,
   parameter int unsigned          CntWidth   = 64,
   parameter logic [CntWidth-1:0]  MaxCycles  = '0,
   parameter bit                   WaitAll    = 1'b1,
   localparam int unsigned         ChanWidth  = (NrChannels > 1) ? $clog2(NrChannels) : 1
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           en_i,
   ara_eoc_monitor_if.slave               exit_if,
   output logic [NrChannels-1:0]          exited_o,
   output logic [NrChannels*CntWidth-1:0] chan_cycles_o,
   output logic [CntWidth-1:0]            cycles_o,
   output logic                           done_o,
   output logic                           pass_o,
   output logic                           timeout_o,
   output logic [ChanWidth-1:0]           fail_chan_o,
   output logic [ExitWidth-2:0]           fail_code_o,
   output logic [1:0]                     state_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e                                state_q, state_d;
   logic                                  done_q, done_d;
   logic                                  timeout_q, timeout_d;
   logic [NrChannels-1:0]                 exited_q;
   logic [NrChannels-1:0][CntWidth-1:0]   chan_cyc_q;
   logic [CntWidth-1:0]                   cycles_q;
   logic                                  fail_q;
   logic [ChanWidth-1:0]                  fail_chan_q;
   logic [ExitWidth-2:0]                  fail_code_q;

   logic [NrChannels-1:0]                 cap;
   logic                                  new_fail;
   logic [ChanWidth-1:0]                  new_fail_chan;
   logic [ExitWidth-2:0]                  new_fail_code;
   logic [NrChannels-1:0]                 exited_nxt;
   logic                                  fail_nxt;
   logic                                  finish_q;
   logic                                  finish_cap;
   logic                                  at_budget;

   // Capture qualification and same-edge failure arbitration. The loop walks
   // from the highest channel down, so the lowest failing index wins.
   always_comb begin
      cap           = '0;
      new_fail      = 1'b0;
      new_fail_chan = '0;
      new_fail_code = '0;
      for (int c = NrChannels - 1; c >= 0; c--) begin
         if (state_q == RUN && exit_if.exit_valid[c] &&
             exit_if.exit_data[c*ExitWidth] && !exited_q[c]) begin
            cap[c] = 1'b1;
            if (exit_if.exit_data[c*ExitWidth+1 +: ExitWidth-1] != '0) begin
               new_fail      = 1'b1;
               new_fail_chan = ChanWidth'(c);
               new_fail_code = exit_if.exit_data[c*ExitWidth+1 +: ExitWidth-1];
            end
         end
      end
   end

   assign exited_nxt = exited_q | cap;
   assign fail_nxt   = fail_q | new_fail;

   // The normal finish uses registered state only, so done lags the deciding
   // capture by one edge. finish_cap also includes this edge's captures. It is
   // used only at the budget edge: a capture that completes the run there
   // beats the timeout.
   assign finish_q   = WaitAll ? ((&exited_q)   | fail_q)   : (|exited_q);
   assign finish_cap = WaitAll ? ((&exited_nxt) | fail_nxt) : (|exited_nxt);
   assign at_budget  = (MaxCycles != '0) && (cycles_q == MaxCycles);

   always_comb begin
      state_d   = state_q;
      done_d    = done_q;
      timeout_d = timeout_q;
      unique case (state_q)
         IDLE: begin
            if (en_i) state_d = RUN;
         end
         RUN: begin
            if (finish_q) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else if (at_budget) begin
               state_d   = DONE;
               done_d    = 1'b1;
               timeout_d = !finish_cap;
            end
         end
         DONE:    state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         done_q      <= 1'b0;
         timeout_q   <= 1'b0;
         exited_q    <= '0;
         chan_cyc_q  <= '0;
         cycles_q    <= '0;
         fail_q      <= 1'b0;
         fail_chan_q <= '0;
         fail_code_q <= '0;
      end else begin
         state_q   <= state_d;
         done_q    <= done_d;
         timeout_q <= timeout_d;
         exited_q  <= exited_nxt;
         for (int c = 0; c < NrChannels; c++) begin
            if (cap[c]) chan_cyc_q[c] <= cycles_q;
         end
         // Counter saturates at all-ones rather than wrapping.
         if (state_q == RUN && cycles_q != '1) cycles_q <= cycles_q + CntWidth'(1);
         if (new_fail && !fail_q) begin
            fail_q      <= 1'b1;
            fail_chan_q <= new_fail_chan;
            fail_code_q <= new_fail_code;
         end
      end
   end

   assign exited_o      = exited_q;
   assign chan_cycles_o = chan_cyc_q;
   assign cycles_o      = cycles_q;
   assign done_o        = done_q;
   assign pass_o        = done_q & ~fail_q & ~timeout_q;
   assign timeout_o     = timeout_q;
   assign fail_chan_o   = fail_chan_q;
   assign fail_code_o   = fail_code_q;
   assign state_o       = state_q;

endmodule
